// File: rtl/rd_ctrl_pkg.sv
// Shared types and encodings for the burst read controller.
// State enum plus tag-store, conflict and fetch command codes.
package rd_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    CHECK_CONFLICT,
    WAIT_CONFLICT,
    ALLOCATE,
    FETCH_REQ,
    WAIT_FETCH,
    STREAM,
    DRAIN
  } state_e;

  localparam logic [2:0] ACC_HIT        = 3'b001;
  localparam logic [2:0] ACC_MISS_CLEAN = 3'b000;
  localparam logic [2:0] ACC_MISS_DIRTY = 3'b100;

  localparam logic [1:0] CMD_LOOKUP  = 2'b00;
  localparam logic [1:0] CMD_ALLOC   = 2'b10;
  localparam logic [1:0] CMD_RELEASE = 2'b11;

  localparam logic [2:0] PS_IDLE  = 3'b000;
  localparam logic [2:0] PS_CHECK = 3'b001;
  localparam logic [2:0] PS_BUSY  = 3'b010;
  localparam logic [2:0] PS_DONE  = 3'b011;

  localparam logic [1:0] FCMD_FETCH    = 2'b01;
  localparam logic [1:0] FCMD_WB_FETCH = 2'b10;

endpackage

// File: rtl/rd_resp_tracker.sv
// Counts returned data beats for a burst and flags the final one.
// done also covers the cycle in which the final beat arrives.
module rd_resp_tracker #(
  parameter int len_w = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [len_w-1:0] len_i,
  input  logic             rvalid_i,
  output logic             last_o,
  output logic             done_o
);

  localparam int CW = len_w + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] total_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      total_q <= {1'b0, len_i} + ONE;
      cnt_q   <= '0;
    end else if (rvalid_i && cnt_q != total_q) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign last_o = rvalid_i && (cnt_q == total_q - ONE);
  assign done_o = (cnt_q == total_q) || last_o;

endmodule

// File: rtl/rd_burst_ctrl.sv
// Burst read controller: tag lookup, conflict wait, line fetch,
// then streams up to two line segments out of the data memory.
module rd_burst_ctrl
  import rd_ctrl_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int list_depth = 4,
  parameter int list_width = 32,
  parameter int max_burst  = 8,
  localparam int tag_w = $clog2(list_depth),
  localparam int off_w = $clog2(list_width),
  localparam int len_w = $clog2(max_burst)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [addr_width-1:0] rd_addr,
  input  logic [len_w-1:0]      rd_len,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_data_last,
  output logic                  acc_req,
  output logic [1:0]            acc_cmd,
  output logic [addr_width-1:0] acc_index,
  output logic [tag_w-1:0]      acc_tag,
  input  logic [2:0]            acc_status,
  input  logic [tag_w-1:0]      return_tag,
  output logic [2:0]            proc_status_r,
  output logic [addr_width-1:0] proc_addr_r,
  input  logic [2:0]            proc_status_w,
  input  logic [addr_width-1:0] proc_addr_w,
  output logic                  fetch_req,
  input  logic                  fetch_gnt,
  output logic [1:0]            fetch_cmd,
  output logic [tag_w-1:0]      fetch_tag,
  output logic [addr_width-1:0] fetch_addr,
  input  logic                  fetch_done,
  output logic                  mem_ren,
  input  logic                  mem_rready,
  output logic [tag_w+off_w-1:0] mem_raddr,
  input  logic [data_width-1:0] mem_rdata,
  input  logic                  mem_rdata_valid
);

  localparam int LW = addr_width - off_w;
  localparam logic [off_w-1:0] OFF_MAX = off_w'(list_width - 1);
  localparam logic [len_w:0]   BEAT_ONE = (len_w + 1)'(1);

  state_e            state_q;
  logic [LW-1:0]     line_q;
  logic [off_w-1:0]  off_q;
  logic [len_w:0]    beats_q;
  logic [tag_w-1:0]  tag_q;
  logic              seg_miss_q;
  logic              dirty_q;
  logic [1:0]        fcmd_q;

  logic [addr_width-1:0] idx;
  logic hs, last_beat, seg_end, conflict, trk_done;

  assign idx       = {line_q, {off_w{1'b0}}};
  assign hs        = (state_q == STREAM) && mem_rready;
  assign last_beat = (beats_q == BEAT_ONE);
  assign seg_end   = hs && (last_beat || off_q == OFF_MAX);
  assign conflict  = (proc_status_w == PS_CHECK || proc_status_w == PS_BUSY)
                  && (proc_addr_w == idx);

  rd_resp_tracker #(.len_w(len_w)) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (state_q == IDLE && rd_valid),
    .len_i    (rd_len),
    .rvalid_i (mem_rdata_valid),
    .last_o   (rd_data_last),
    .done_o   (trk_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      off_q      <= '0;
      beats_q    <= '0;
      tag_q      <= '0;
      seg_miss_q <= 1'b0;
      dirty_q    <= 1'b0;
      fcmd_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (rd_valid) begin
          line_q  <= rd_addr[addr_width-1:off_w];
          off_q   <= rd_addr[off_w-1:0];
          beats_q <= {1'b0, rd_len} + BEAT_ONE;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (acc_status == ACC_HIT) begin
            tag_q      <= return_tag;
            seg_miss_q <= 1'b0;
            state_q    <= STREAM;
          end else if (acc_status == ACC_MISS_CLEAN ||
                       acc_status == ACC_MISS_DIRTY) begin
            dirty_q <= (acc_status == ACC_MISS_DIRTY);
            state_q <= CHECK_CONFLICT;
          end
        end
        CHECK_CONFLICT:
          state_q <= conflict ? WAIT_CONFLICT : ALLOCATE;
        WAIT_CONFLICT:
          if (proc_status_w == PS_DONE) state_q <= LOOKUP;
        ALLOCATE: begin
          tag_q      <= return_tag;
          seg_miss_q <= 1'b1;
          fcmd_q     <= dirty_q ? FCMD_WB_FETCH : FCMD_FETCH;
          state_q    <= FETCH_REQ;
        end
        FETCH_REQ:
          if (fetch_gnt) state_q <= WAIT_FETCH;
        WAIT_FETCH:
          if (fetch_done) state_q <= STREAM;
        STREAM: if (hs) begin
          off_q   <= off_q + off_w'(1);
          beats_q <= beats_q - BEAT_ONE;
          if (seg_end) begin
            if (!last_beat) begin
              line_q  <= line_q + LW'(1);
              off_q   <= '0;
              state_q <= LOOKUP;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN:
          if (trk_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data       = mem_rdata;
  assign rd_data_valid = mem_rdata_valid;

  always_comb begin
    rd_ready      = 1'b0;
    acc_req       = 1'b0;
    acc_cmd       = 2'b00;
    acc_index     = '0;
    acc_tag       = '0;
    proc_status_r = PS_IDLE;
    fetch_req     = 1'b0;
    fetch_cmd     = 2'b00;
    fetch_tag     = '0;
    fetch_addr    = '0;
    mem_ren       = 1'b0;
    mem_raddr     = '0;
    unique case (state_q)
      IDLE: rd_ready = 1'b1;
      LOOKUP: begin
        acc_req   = 1'b1;
        acc_cmd   = CMD_LOOKUP;
        acc_index = idx;
      end
      CHECK_CONFLICT: proc_status_r = PS_CHECK;
      ALLOCATE: begin
        acc_req       = 1'b1;
        acc_cmd       = CMD_ALLOC;
        acc_index     = idx;
        proc_status_r = PS_BUSY;
      end
      FETCH_REQ: begin
        fetch_req     = 1'b1;
        fetch_cmd     = fcmd_q;
        fetch_tag     = tag_q;
        fetch_addr    = idx;
        proc_status_r = PS_BUSY;
      end
      WAIT_FETCH: proc_status_r = PS_BUSY;
      STREAM: begin
        mem_ren   = 1'b1;
        mem_raddr = {tag_q, off_q};
        if (seg_miss_q)
          proc_status_r = seg_end ? PS_DONE : PS_BUSY;
        if (seg_end) begin
          acc_req   = 1'b1;
          acc_cmd   = CMD_RELEASE;
          acc_index = idx;
          acc_tag   = tag_q;
        end
      end
      default: ;
    endcase
    proc_addr_r = (proc_status_r != PS_IDLE) ? idx : '0;
  end

endmodule

// File: doc/rd_burst_ctrl.md
RD_BURST_CTRL -- requirements
Module: rd_burst_ctrl

Interface
REQ-001 SHALL have these parameters, one per line: name, default, meaning.
- addr_width, 32, byte/word address width.
- data_width, 32, data word width.
- list_depth, 4, cache lines; tag_w = clog2(list_depth).
- list_width, 32, words per line; off_w = clog2(list_width).
- max_burst, 8, max beats per request, power of 2, <= list_width; len_w = clog2(max_burst).
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk, in, 1, clock.
  - rst_n, in, 1, async active-low reset.
- Read request:
  - rd_valid/rd_ready, in/out, 1, read request handshake.
  - rd_addr, in, addr_width, start word address.
  - rd_len, in, len_w, beats minus 1.
- Read data:
  - rd_data, out, data_width, = mem_rdata.
  - rd_data_valid, out, 1, = mem_rdata_valid.
  - rd_data_last, out, 1, final beat of burst.
- Tag lookup:
  - acc_req, out, 1, tag access.
  - acc_cmd, out, 2, 00 lookup / 10 allocate / 11 release.
  - acc_index, out, addr_width, line-aligned address.
  - acc_tag, out, tag_w, tag for release.
  - acc_status, in, 3, 001 hit / 000 clean miss / 100 dirty miss / other retry.
  - return_tag, in, tag_w, hit or allocated tag.
- Read/write conflict check:
  - proc_status_r, out, 3, 000 idle / 001 check / 010 busy / 011 done.
  - proc_addr_r, out, addr_width, = acc_index.
  - proc_status_w, in, 3, writer status.
  - proc_addr_w, in, addr_width, writer line address.
- Line fetch:
  - fetch_req, out, 1, fetch request.
  - fetch_gnt, in, 1, fetch grant.
  - fetch_cmd, out, 2, 01 fetch / 10 writeback+fetch.
  - fetch_tag, out, tag_w, target tag.
  - fetch_addr, out, addr_width, = acc_index.
  - fetch_done, in, 1, fetch complete.
- Data memory:
  - mem_ren/mem_rready, out/in, 1, memory read handshake.
  - mem_raddr, out, tag_w+off_w, {tag, offset}.
  - mem_rdata, in, data_width, read data.
  - mem_rdata_valid, in, 1, read data valid.

Function
REQ-003 SHALL use states IDLE, LOOKUP, CHECK_CONFLICT, WAIT_CONFLICT, ALLOCATE, FETCH_REQ, WAIT_FETCH, STREAM, DRAIN.
REQ-004 SHALL assert rd_ready only in IDLE.
- On handshake: capture rd_addr and beats = rd_len+1, clear response counter, go to LOOKUP.
REQ-005 LOOKUP SHALL take one cycle: acc_req=1, acc_cmd=00, acc_index = current line address.
- acc_status 001: capture return_tag, clear seg_miss, go to STREAM.
- acc_status 000 or 100: go to CHECK_CONFLICT.
- Any other value: stay in LOOKUP (retry next cycle).
REQ-006 CHECK_CONFLICT SHALL drive proc_status_r=001.
- Conflict = proc_status_w in {001,010} and proc_addr_w == proc_addr_r → WAIT_CONFLICT.
- Otherwise → ALLOCATE.
REQ-007 WAIT_CONFLICT SHALL return to LOOKUP the cycle after proc_status_w==011 is seen, so the lookup is re-run.
REQ-008 ALLOCATE SHALL be one cycle: acc_req=1, acc_cmd=10.
- Register return_tag and set seg_miss.
- Register fetch_cmd = 01 for status 000, 10 for status 100.
- → FETCH_REQ.
REQ-009 FETCH_REQ SHALL hold fetch_req=1 until fetch_gnt, then go to WAIT_FETCH.
- fetch_tag and fetch_addr SHALL stay stable throughout.
REQ-010 WAIT_FETCH SHALL go to STREAM on fetch_done.
REQ-011 STREAM SHALL hold mem_ren=1 with mem_raddr = {tag_ff, offset}.
- Each mem handshake increments the offset and decrements beats.
- On the handshake that ends the segment: acc_req=1, acc_cmd=11, acc_tag=tag_ff.
REQ-012 A segment SHALL end on the last beat or when offset == list_width-1.
- If beats remain: line address +1 (modulo 2^addr_width), offset=0, → LOOKUP.
- Otherwise → DRAIN.
REQ-013 A burst SHALL span at most two line segments.
REQ-014 DRAIN SHALL go to IDLE once returned beats equal requested beats.
- That can happen in the same cycle as the final rd_data_valid.
REQ-015 The response counter SHALL count mem_rdata_valid beats.
- rd_data_last = mem_rdata_valid && count == beats_total-1.
REQ-016 proc_status_r SHALL be:
- 001 in CHECK_CONFLICT.
- 010 in ALLOCATE/FETCH_REQ/WAIT_FETCH, and in STREAM when seg_miss.
- 011 on the final STREAM handshake of a seg_miss segment.
- 000 otherwise.
REQ-017 Outputs not driven by the active state SHALL be 0.

Reset
REQ-018 On rst_n low, immediately and even mid-burst:
- State = IDLE.
- All registers and counters = 0.
- rd_ready=1.
- All other outputs = 0, except rd_data and rd_data_valid, which pass through.

Structure
REQ-019 Package rd_ctrl_pkg SHALL hold:
- The state enum.
- Encodings for acc_status, acc_cmd, proc_status and fetch_cmd.
REQ-020 The response counter and last-beat generation SHALL be sub-module rd_resp_tracker.

Verification
REQ-021 Hit, rd_addr=0x40, rd_len=3:
- One LOOKUP, then 4 mem reads at offsets 0-3.
- acc_cmd 11 on beat 4.
- rd_data_last on the 4th data beat; rd_ready back in IDLE.
REQ-022 Clean miss, then fetch_gnt after 2 cycles:
- fetch_cmd=01, fetch_req high for 3 cycles.
- STREAM the cycle after fetch_done.
- proc_status_r 010 then 011 on the final handshake.
REQ-023 Dirty miss while writer has proc_status_w=010 on the same line:
- Held in WAIT_CONFLICT.
- After 011: re-LOOKUP, then fetch_cmd=10.
REQ-024 list_width=32, rd_addr offset 30, rd_len=3:
- Segment 1 offsets 30-31, release, LOOKUP of next line, segment 2 offsets 0-1.
- Single rd_data_last.
REQ-025 mem_rready low for 5 cycles mid-STREAM:
- mem_raddr held, no beat skipped.
- rst_n pulsed mid-burst → all outputs at reset values.
